mfp_ahb_uart_tx: RTL and testbench

//  AHB-Lite slave UART transmitter on the mfp_sys peripheral bus, a downstream consumer of the core's HADDR/HWDATA/HWRITE.

---
 rtl/mfp_ahb_uart_tx.sv | 203 ++++++++++++++++++++
 tb/tb_mfp_ahb_uart_tx.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mfp_ahb_uart_tx.sv
// AHB-Lite zero-wait-state UART transmitter: TX FIFO, 8N1 serializer, status and level IRQ.
module mfp_ahb_uart_tx #(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] DIV_RESET  = 16'd433
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [3:0]  HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADY,
  output logic        HRESP,
  output logic        UART_TX,
  output logic        TX_IRQ
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] LAST_C  = (AW+1)'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // byte-lane and low address bits carry no information for this block
  logic unused_bits;
  assign unused_bits = ^{HADDR[1:0], HWDATA[31:16]};

  assign HREADY = 1'b1;
  assign HRESP  = 1'b0;

  // ---- bus address phase ----
  logic       dp_act, dp_write;
  logic [1:0] dp_addr;
  logic       wr_en, rd_en;

  // capture address phase for the following data phase
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_act   <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= 2'd0;
    end else begin
      dp_act   <= HSEL & HTRANS[1];
      dp_write <= HWRITE;
      dp_addr  <= HADDR[3:2];
    end
  end

  assign wr_en = dp_act & dp_write;
  assign rd_en = dp_act & ~dp_write;

  // ---- FIFO ----
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr, count;
  logic        empty, full, push_req, push, pop;
  logic [7:0]  head;

  assign empty    = (count == '0);
  assign full     = (count == DEPTH_C);
  assign push_req = wr_en & (dp_addr == 2'd0);
  // a simultaneous pop frees a slot, so a push into a full FIFO still lands
  assign push     = push_req & (~full | pop);
  assign head     = mem[rptr[AW-1:0]];

  // storage needs no reset; pointers define validity
  always_ff @(posedge HCLK) begin
    if (push) mem[wptr[AW-1:0]] <= HWDATA[7:0];
  end

  // pointers and occupancy
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= (wptr == LAST_C) ? '0 : wptr + 1'b1;
      if (pop)  rptr <= (rptr == LAST_C) ? '0 : rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---- control registers ----
  logic [15:0] divisor;
  logic        ie, ovr;

  // DIVISOR/CTRL writes, sticky overflow cleared by a STATUS read (a new overflow wins)
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      divisor <= DIV_RESET;
      ie      <= 1'b0;
      ovr     <= 1'b0;
    end else begin
      if (wr_en && dp_addr == 2'd2)
        divisor <= (HWDATA[15:0] == 16'd0) ? 16'd1 : HWDATA[15:0];
      if (wr_en && dp_addr == 2'd3)
        ie <= HWDATA[0];
      if (push_req && full && !pop) ovr <= 1'b1;
      else if (rd_en && dp_addr == 2'd1) ovr <= 1'b0;
    end
  end

  // ---- serializer ----
  state_t      state, state_d;
  logic [7:0]  shreg, shreg_d;
  logic [2:0]  bitcnt, bitcnt_d;
  logic [15:0] baud, baud_d, fdiv, fdiv_d;
  logic        tx_d, load, busy;

  assign busy = (state != S_IDLE);

  // next state; the frame-local divisor copy isolates a frame from mid-frame DIVISOR writes
  always_comb begin
    state_d  = state;
    shreg_d  = shreg;
    bitcnt_d = bitcnt;
    baud_d   = baud;
    fdiv_d   = fdiv;
    load     = 1'b0;
    pop      = 1'b0;
    case (state)
      S_IDLE:  if (!empty) load = 1'b1;
      S_START: begin
        if (baud == 16'd0) begin
          baud_d   = fdiv;
          bitcnt_d = 3'd0;
          state_d  = S_DATA;
        end else baud_d = baud - 16'd1;
      end
      S_DATA: begin
        if (baud == 16'd0) begin
          baud_d   = fdiv;
          shreg_d  = {1'b0, shreg[7:1]};
          bitcnt_d = bitcnt + 3'd1;
          if (bitcnt == 3'd7) state_d = S_STOP;
        end else baud_d = baud - 16'd1;
      end
      S_STOP: begin
        if (baud == 16'd0) begin
          if (!empty) load = 1'b1;
          else        state_d = S_IDLE;
        end else baud_d = baud - 16'd1;
      end
      default: state_d = S_IDLE;
    endcase
    if (load) begin
      pop     = 1'b1;
      shreg_d = head;
      fdiv_d  = divisor;
      baud_d  = divisor;
      state_d = S_START;
    end
    // line level follows the state being entered, so the output is a clean flop
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shreg_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // serializer registers and output flop; reset forces the line idle at once
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state   <= S_IDLE;
      shreg   <= 8'd0;
      bitcnt  <= 3'd0;
      baud    <= 16'd0;
      fdiv    <= 16'd0;
      UART_TX <= 1'b1;
    end else begin
      state   <= state_d;
      shreg   <= shreg_d;
      bitcnt  <= bitcnt_d;
      baud    <= baud_d;
      fdiv    <= fdiv_d;
      UART_TX <= tx_d;
    end
  end

  // drain interrupt, one cycle behind status
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) TX_IRQ <= 1'b0;
    else          TX_IRQ <= ie & empty & ~busy;
  end

  // read mux from the registered data-phase address
  always_comb begin
    HRDATA = 32'd0;
    if (rd_en) begin
      case (dp_addr)
        2'd1:    HRDATA = {26'd0, ovr, busy, full, empty, 2'b00};
        2'd2:    HRDATA = {16'd0, divisor};
        2'd3:    HRDATA = {31'd0, ie};
        default: HRDATA = 32'd0;
      endcase
    end
  end
endmodule

// File: tb/tb_mfp_ahb_uart_tx.sv
// Scoreboard bench: stimulus pushes expected frames/read data, monitors pop and compare.
module tb_mfp_ahb_uart_tx;
  localparam int DEPTH = 16;

  logic        HCLK = 1'b0, HRESETn = 1'b1;
  logic        HSEL = 1'b0, HWRITE = 1'b0;
  logic [3:0]  HADDR = 4'd0;
  logic [1:0]  HTRANS = 2'd0;
  logic [31:0] HWDATA = 32'd0;
  logic [31:0] HRDATA;
  logic        HREADY, HRESP, UART_TX, TX_IRQ;

  mfp_ahb_uart_tx #(.FIFO_DEPTH(DEPTH), .DIV_RESET(16'd433)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
    .UART_TX(UART_TX), .TX_IRQ(TX_IRQ));

  always #5 HCLK = ~HCLK;

  int n_cmp = 0, n_bad = 0, cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  typedef struct { logic [7:0] data; int bitlen; } frame_t;
  typedef struct { bit chk; logic [31:0] exp; string name; } rd_t;
  typedef struct { logic [31:0] data; int cyc; } raw_t;
  frame_t frm_q[$];
  rd_t    rd_q[$];
  raw_t   raw_q[$];
  int     frame_starts[$];
  bit     in_frame = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // bus monitor: data phase of every read pops one entry
  logic rd_dp = 1'b0;
  always @(posedge HCLK) rd_dp <= HRESETn & HSEL & HTRANS[1] & ~HWRITE;

  initial begin : mon_bus
    rd_t r;
    forever begin
      @(negedge HCLK);
      if (rd_dp) begin
        if (rd_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_read: got 0x%0h want no read", HRDATA);
        end else begin
          r = rd_q.pop_front();
          if (r.chk) check(r.name, HRDATA, r.exp);
          else raw_q.push_back('{HRDATA, cyc});
        end
      end
    end
  end

  // line monitor: checks every sample of an 8N1 frame against the expected byte and bit length
  initial begin : mon_uart
    frame_t e;
    bit ok, abort;
    logic expb;
    logic [7:0] got;
    forever begin
      @(negedge HCLK);
      if (HRESETn && UART_TX === 1'b0) begin
        in_frame = 1'b1;
        frame_starts.push_back(cyc);
        if (frm_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL spurious_frame: got start bit at cycle %0d want idle line", cyc);
          for (int i = 0; i < 4000 && UART_TX !== 1'b1; i++) @(negedge HCLK);
        end else begin
          e = frm_q.pop_front();
          ok = 1'b1; abort = 1'b0; got = 8'd0;
          for (int b = 0; b < 10 && !abort; b++)
            for (int c = 0; c < e.bitlen && !abort; c++) begin
              if (b != 0 || c != 0) @(negedge HCLK);
              if (!HRESETn) abort = 1'b1;
              else begin
                expb = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : e.data[b-1];
                if (b >= 1 && b <= 8 && c == e.bitlen / 2) got[b-1] = UART_TX;
                if (UART_TX !== expb) ok = 1'b0;
              end
            end
          if (!abort) begin
            n_cmp++;
            if (!ok) begin
              n_bad++;
              $display("FAIL frame: got byte 0x%02h (waveform wrong) want 0x%02h at %0d cycles/bit",
                       got, e.data, e.bitlen);
            end
          end
        end
        in_frame = 1'b0;
      end
    end
  end

  task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
    @(posedge HCLK); #1 HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
    @(posedge HCLK); #1 HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
  endtask

  task automatic bus_rd(input logic [3:0] a, input logic [31:0] exp, input string name);
    @(posedge HCLK); #1 HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
    rd_q.push_back('{1'b1, exp, name});
    @(posedge HCLK); #1 HSEL = 1'b0; HTRANS = 2'b00;
  endtask

  // back-to-back reads, results captured in raw_q with their cycle stamp
  task automatic bus_rd_burst(input logic [3:0] a, input int n);
    @(posedge HCLK); #1 HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
    rd_q.push_back('{1'b0, 32'd0, "raw"});
    repeat (n - 1) begin
      @(posedge HCLK); #1 rd_q.push_back('{1'b0, 32'd0, "raw"});
    end
    @(posedge HCLK); #1 HSEL = 1'b0; HTRANS = 2'b00;
  endtask

  task automatic tx_byte(input logic [7:0] d, input int bitlen);
    frm_q.push_back('{d, bitlen});
    bus_wr(4'h0, {24'd0, d});
  endtask

  task automatic wait_idle(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge HCLK);
      if (frm_q.size() == 0 && !in_frame) done = 1'b1;
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: got %0d frames pending want 0", frm_q.size());
    end
    repeat (3) @(negedge HCLK);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  initial begin : stim
    int ns, k, drop, irq_cyc;
    // reset values
    #1 HRESETn = 1'b0;
    repeat (3) @(posedge HCLK);
    #1;
    check("rst_uart_tx", {31'd0, UART_TX}, 32'd1);
    check("rst_irq", {31'd0, TX_IRQ}, 32'd0);
    check("rst_hrdata", HRDATA, 32'd0);
    check("hready", {31'd0, HREADY}, 32'd1);
    check("hresp", {31'd0, HRESP}, 32'd0);
    HRESETn = 1'b1;
    bus_rd(4'h4, 32'h04, "rst_status");
    bus_rd(4'h8, 32'd433, "rst_divisor");
    bus_rd(4'hC, 32'd0, "rst_ctrl");
    bus_rd(4'h0, 32'd0, "txdata_read_zero");
    bus_wr(4'h8, 32'd0);
    bus_rd(4'h8, 32'd1, "div_zero_clamp");
    bus_wr(4'h4, 32'hFF);
    bus_rd(4'h4, 32'h04, "status_write_ignored");

    // single frame, BUSY drop 40 cycles after start
    bus_wr(4'h8, 32'd3);
    ns = frame_starts.size();
    raw_q.delete();
    tx_byte(8'h55, 4);
    bus_rd_burst(4'h4, 60);
    wait_idle(500);
    drop = -1;
    if (frame_starts.size() > ns) begin
      k = frame_starts[ns];
      foreach (raw_q[i])
        if (drop < 0 && raw_q[i].cyc >= k && raw_q[i].data[4] == 1'b0) drop = raw_q[i].cyc;
      check("busy_drop_delay", drop - k, 32'd40);
    end else check("frame_55_started", frame_starts.size(), ns + 1);
    check("hrdata_idle", HRDATA, 32'd0);

    // contiguous frames and drain interrupt
    ns = frame_starts.size();
    tx_byte(8'hA5, 4);
    tx_byte(8'h3C, 4);
    bus_wr(4'hC, 32'd1);
    irq_cyc = -1;
    for (int i = 0; i < 400 && irq_cyc < 0; i++) begin
      @(negedge HCLK);
      if (TX_IRQ === 1'b1) irq_cyc = cyc;
    end
    wait_idle(300);
    if (frame_starts.size() >= ns + 2) begin
      check("frame_gap", frame_starts[ns+1] - frame_starts[ns], 32'd40);
      check("irq_delay", irq_cyc - frame_starts[ns+1], 32'd41);
    end else check("two_frames_started", frame_starts.size(), ns + 2);
    bus_wr(4'hC, 32'd0);
    repeat (2) @(posedge HCLK);
    #1 check("irq_cleared_by_ie", {31'd0, TX_IRQ}, 32'd0);

    // overflow: one byte in the serializer, DEPTH in the FIFO, one dropped
    bus_wr(4'h8, 32'd7);
    for (int i = 0; i <= DEPTH; i++) tx_byte(8'h80 + 8'(i), 8);
    bus_wr(4'h0, 32'hEE);
    bus_rd(4'h4, 32'h38, "status_ovr_full");
    bus_rd(4'h4, 32'h18, "status_ovr_cleared");
    wait_idle(2000);
    bus_rd(4'h4, 32'h04, "status_after_drain");

    // mid-frame divisor change applies to the next frame
    bus_wr(4'h8, 32'd3);
    tx_byte(8'hC3, 4);
    tx_byte(8'h96, 8);
    repeat (6) @(posedge HCLK);
    bus_wr(4'h8, 32'd7);
    wait_idle(500);
    bus_rd(4'h8, 32'd7, "div_readback");

    // reset mid-DATA with bytes queued
    bus_wr(4'h8, 32'd3);
    frm_q.push_back('{8'h00, 4});
    bus_wr(4'h0, 32'h00);
    bus_wr(4'h0, 32'h11);
    bus_wr(4'h0, 32'h22);
    bus_wr(4'h0, 32'h33);
    repeat (14) @(posedge HCLK);
    @(negedge HCLK);
    #2 HRESETn = 1'b0;
    #1;
    check("reset_async_tx", {31'd0, UART_TX}, 32'd1);
    check("reset_async_irq", {31'd0, TX_IRQ}, 32'd0);
    repeat (3) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    bus_rd(4'h4, 32'h04, "status_after_reset");
    bus_rd(4'h8, 32'd433, "div_after_reset");
    repeat (300) @(posedge HCLK);
    @(negedge HCLK);
    check("frames_pending", frm_q.size(), 32'd0);
    check("reads_pending", rd_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
